mul_div_unit: RTL and testbench

Parametrised, multi-cycle signed multiply/divide unit that produces double-width results on the `Chigh`/`Clow` pair. The datapath's ALU hands it MUL and DIV operations, using a `start`/`done` handshake. Multiply uses radix-4 Booth recoding, one partial product per cycle. Divide uses non-restoring division, one quotient bit per cycle, followed by a sign-fixup cycle.

---
 rtl/mul_div_unit.sv | 171 +++++++++++++++++
 tb/tb_mul_div_unit.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Multi-cycle signed multiply/divide unit: radix-4 Booth multiply and
// non-restoring divide, double-width result on Chigh/Clow, start/done handshake.
module mul_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Chigh,
  output logic [WIDTH-1:0] Clow,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int unsigned W  = WIDTH;
  localparam int unsigned AW = WIDTH + 2;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t          state_q, state_d;
  logic            op_q, op_d;
  logic [W-1:0]    a_q, a_d;
  logic            b_neg_q, b_neg_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [W:0]      lo_q, lo_d;
  logic [AW-1:0]   dvs_q, dvs_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    chigh_d, clow_d;
  logic            busy_d, done_d, dbz_d;

  logic [W-1:0]    a_abs, b_abs;
  logic [AW-1:0]   m_ext, sel, sum, shl, rnew;
  logic [W-1:0]    r_fix, q_fix, r_out;

  assign a_abs = A[W-1] ? W'(-A) : A;
  assign b_abs = B[W-1] ? W'(-B) : B;
  assign m_ext = {{2{a_q[W-1]}}, a_q};

  // Next-state, datapath and output logic
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_neg_d = b_neg_q;
    acc_d   = acc_q;
    lo_d    = lo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    chigh_d = Chigh;
    clow_d  = Clow;
    dbz_d   = div_by_zero;
    done_d  = 1'b0;
    sel     = '0;
    sum     = '0;
    shl     = '0;
    rnew    = '0;
    r_fix   = '0;
    q_fix   = '0;
    r_out   = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = op;
          a_d     = A;
          b_neg_d = B[W-1];
          dbz_d   = 1'b0;
          acc_d   = '0;
          if (op) begin
            cnt_d   = CW'(W);
            lo_d    = {1'b0, a_abs};
            dvs_d   = {2'b00, b_abs};
            state_d = (B == '0) ? FIX : RUN;
          end else begin
            cnt_d   = CW'(W / 2);
            lo_d    = {B, 1'b0};
            dvs_d   = '0;
            state_d = RUN;
          end
        end
      end

      RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_d == '0) begin
          state_d = FIX;
        end
        if (!op_q) begin
          // Booth digit from {b(2i+1), b(2i), b(2i-1)}
          case (lo_q[2:0])
            3'b001, 3'b010: sel = m_ext;
            3'b011:         sel = m_ext << 1;
            3'b100:         sel = AW'(-(m_ext << 1));
            3'b101, 3'b110: sel = AW'(-m_ext);
            default:        sel = '0;
          endcase
          sum   = acc_q + sel;
          acc_d = {{2{sum[AW-1]}}, sum[AW-1:2]};
          lo_d  = {sum[1:0], lo_q[W:2]};
        end else begin
          shl   = {acc_q[AW-2:0], lo_q[W-1]};
          rnew  = acc_q[AW-1] ? (shl + dvs_q) : (shl - dvs_q);
          acc_d = rnew;
          lo_d  = {1'b0, lo_q[W-2:0], ~rnew[AW-1]};
        end
      end

      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (!op_q) begin
          chigh_d = acc_q[W-1:0];
          clow_d  = lo_q[W:1];
        end else if (dvs_q == '0) begin
          chigh_d = a_q;
          clow_d  = '1;
          dbz_d   = 1'b1;
        end else begin
          // Restore a negative remainder, then apply operand signs
          r_fix   = acc_q[AW-1] ? W'(acc_q + dvs_q) : acc_q[W-1:0];
          q_fix   = (a_q[W-1] ^ b_neg_q) ? W'(-lo_q[W-1:0]) : lo_q[W-1:0];
          r_out   = a_q[W-1] ? W'(-r_fix) : r_fix;
          chigh_d = r_out;
          clow_d  = q_fix;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q     <= IDLE;
      op_q        <= 1'b0;
      a_q         <= '0;
      b_neg_q     <= 1'b0;
      acc_q       <= '0;
      lo_q        <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
      Chigh       <= '0;
      Clow        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_neg_q     <= b_neg_d;
      acc_q       <= acc_d;
      lo_q        <= lo_d;
      dvs_q       <= dvs_d;
      cnt_q       <= cnt_d;
      Chigh       <= chigh_d;
      Clow        <= clow_d;
      busy        <= busy_d;
      done        <= done_d;
      div_by_zero <= dbz_d;
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: arithmetic/latency reference model checked every
// cycle, plus directed vectors with hand-computed results.
module tb_mul_div_unit;

  logic        clock = 1'b0;
  logic        clear_n = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] chigh, clow;
  logic        busy, done, dbz;

  logic        start8 = 1'b0;
  logic        op8 = 1'b0;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic [7:0]  chigh8, clow8;
  logic        busy8, done8, dbz8;

  int total = 0;
  int bad = 0;

  mul_div_unit #(.WIDTH(32)) dut (
    .clock(clock), .clear_n(clear_n), .start(start), .op(op), .A(a), .B(b),
    .Chigh(chigh), .Clow(clow), .busy(busy), .done(done), .div_by_zero(dbz)
  );

  mul_div_unit #(.WIDTH(8)) dut8 (
    .clock(clock), .clear_n(clear_n), .start(start8), .op(op8), .A(a8), .B(b8),
    .Chigh(chigh8), .Clow(clow8), .busy(busy8), .done(done8), .div_by_zero(dbz8)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference result {div_by_zero, Chigh, Clow} from plain signed arithmetic
  function automatic logic [64:0] ref_op(input logic o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, p, q, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (!o) begin
      p = sx * sy;
      return {1'b0, p};
    end else if (y == 32'd0) begin
      return {1'b1, x, 32'hFFFFFFFF};
    end else begin
      q = sx / sy;
      r = sx % sy;
      return {1'b0, r[31:0], q[31:0]};
    end
  endfunction

  logic        m_busy = 1'b0, m_done = 1'b0, m_dbz = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [64:0] pend = '0;
  int          remain = 0;

  // Model: result appears a fixed number of edges after acceptance
  always @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_dbz <= 1'b0;
      m_hi <= '0; m_lo <= '0; pend <= '0; remain <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (remain == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          {m_dbz, m_hi, m_lo} <= pend;
        end
        remain <= remain - 1;
      end else if (start) begin
        pend   <= ref_op(op, a, b);
        m_busy <= 1'b1;
        m_dbz  <= 1'b0;
        remain <= !op ? 17 : ((b == 32'd0) ? 1 : 33);
      end
    end
  end

  always @(negedge clock) begin
    if (clear_n) begin
      check("busy", 64'(busy), 64'(m_busy));
      check("done", 64'(done), 64'(m_done));
      check("chigh", 64'(chigh), 64'(m_hi));
      check("clow", 64'(clow), 64'(m_lo));
      check("div_by_zero", 64'(dbz), 64'(m_dbz));
    end
  end

  task automatic launch(input logic o, input logic [31:0] x, input logic [31:0] y);
    @(posedge clock); #1;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int edges);
    bit seen = 1'b0;
    edges = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clock); #1;
      edges++;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL timeout: no done within %0d edges", budget);
      edges = -1;
    end
  endtask

  int lat;
  int done_seen;

  initial begin
    // Reset state
    repeat (2) @(posedge clock);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_chigh", 64'(chigh), 64'd0);
    check("rst_clow", 64'(clow), 64'd0);
    clear_n = 1'b1;

    // 6 * -7 = -42
    launch(1'b0, 32'd6, 32'hFFFFFFF9);
    wait_done(40, lat);
    check("mul_lat", 64'(lat), 64'd17);
    check("mul_hi", 64'(chigh), 64'hFFFFFFFF);
    check("mul_lo", 64'(clow), 64'hFFFFFFD6);
    check("model_mul_lo", 64'(m_lo), 64'hFFFFFFD6);

    // Most-negative squared
    launch(1'b0, 32'h80000000, 32'h80000000);
    wait_done(40, lat);
    check("mulmn_hi", 64'(chigh), 64'h40000000);
    check("mulmn_lo", 64'(clow), 64'h0);

    // WIDTH=8 instance: 0x80 * 0x80
    @(posedge clock); #1;
    start8 = 1'b1; op8 = 1'b0; a8 = 8'h80; b8 = 8'h80;
    @(posedge clock); #1;
    start8 = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clock); #1;
      if (done8) begin
        lat = i;
        break;
      end
    end
    check("mul8_lat", 64'(lat), 64'd5);
    check("mul8_hi", 64'(chigh8), 64'h40);
    check("mul8_lo", 64'(clow8), 64'h00);

    // -7 / 2 = -3 rem -1
    launch(1'b1, 32'hFFFFFFF9, 32'd2);
    wait_done(40, lat);
    check("div_lat", 64'(lat), 64'd33);
    check("div_q", 64'(clow), 64'hFFFFFFFD);
    check("div_r", 64'(chigh), 64'hFFFFFFFF);
    check("model_div_q", 64'(m_lo), 64'hFFFFFFFD);

    // Overflow: most-negative / -1
    launch(1'b1, 32'h80000000, 32'hFFFFFFFF);
    wait_done(40, lat);
    check("ovf_q", 64'(clow), 64'h80000000);
    check("ovf_r", 64'(chigh), 64'h0);
    check("ovf_dbz", 64'(dbz), 64'd0);

    // Divide by zero
    launch(1'b1, 32'd5, 32'd0);
    wait_done(5, lat);
    check("dbz_lat", 64'(lat), 64'd1);
    check("dbz_flag", 64'(dbz), 64'd1);
    check("dbz_q", 64'(clow), 64'hFFFFFFFF);
    check("dbz_r", 64'(chigh), 64'd5);

    // Next accepted start clears the flag
    launch(1'b0, 32'd9, 32'hFFFFFFFF);
    check("dbz_clear", 64'(dbz), 64'd0);
    wait_done(40, lat);
    check("mul9_lo", 64'(clow), 64'hFFFFFFF7);

    // Start while busy is ignored; start in the done cycle is accepted
    @(posedge clock); #1;
    start = 1'b1; op = 1'b0; a = 32'd3; b = 32'd4;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    start = 1'b1; op = 1'b1; a = 32'd100; b = 32'd7;
    @(posedge clock); #1;
    start = 1'b0;
    wait_done(40, lat);
    check("ign_lat", 64'(lat), 64'd12);
    check("ign_lo", 64'(clow), 64'd12);
    check("ign_hi", 64'(chigh), 64'd0);
    start = 1'b1; op = 1'b1; a = 32'd100; b = 32'd7;
    @(posedge clock); #1;
    start = 1'b0;
    check("b2b_busy", 64'(busy), 64'd1);
    wait_done(40, lat);
    check("b2b_lat", 64'(lat), 64'd33);
    check("b2b_q", 64'(clow), 64'd14);
    check("b2b_r", 64'(chigh), 64'd2);

    // Reset mid-divide
    launch(1'b1, 32'd1000, 32'd3);
    repeat (10) @(posedge clock);
    #2;
    clear_n = 1'b0;
    #1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_chigh", 64'(chigh), 64'd0);
    check("mid_rst_clow", 64'(clow), 64'd0);
    check("mid_rst_dbz", 64'(dbz), 64'd0);
    @(posedge clock); #1;
    clear_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock); #1;
      if (done) done_seen++;
    end
    check("no_done_after_rst", 64'(done_seen), 64'd0);

    launch(1'b0, 32'd2, 32'd3);
    wait_done(40, lat);
    check("post_rst_lat", 64'(lat), 64'd17);
    check("post_rst_lo", 64'(clow), 64'd6);

    repeat (3) @(posedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
